ins_fetch_ctrl: RTL and testbench

- Sequences the 256x16 asynchronous-read instruction ROM: owns the program counter, drives the ROM address, and latches the returned word into an instruction register (IR).
- Presents the IR to the decode stage over a valid/ready handshake.
- Supports PC redirect (branch/jump) with IR flush, back-pressure stall, and halt on a reserved opcode.
- Sits between the instruction ROM and the decode/register-file stage of the single-cycle-read datapath.

---
 rtl/ins_fetch_ctrl_pkg.sv | 26 ++
 rtl/ins_fetch_ir.sv | 43 ++++
 rtl/ins_fetch_ctrl.sv | 105 ++++++++++
 tb/tb_ins_fetch_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ins_fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: FSM encoding, halt opcode and instruction field positions.
// Decode reuses the field positions so both stages agree on the instruction layout.
package ins_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHalt  = 2'd2
  } fetch_state_e;

  localparam logic [6:0] HaltOpc = 7'h7F;

  localparam int unsigned OpcMsb = 15;
  localparam int unsigned OpcLsb = 9;
  localparam int unsigned FldAMsb = 8;
  localparam int unsigned FldALsb = 6;
  localparam int unsigned FldBMsb = 5;
  localparam int unsigned FldBLsb = 3;
  localparam int unsigned FldCMsb = 2;
  localparam int unsigned FldCLsb = 0;

  function automatic logic [6:0] ins_opcode(input logic [15:0] ins);
    return ins[OpcMsb:OpcLsb];
  endfunction

endpackage

// File: rtl/ins_fetch_ir.sv
// Instruction register with valid/ready handshake toward decode.
// Flush beats both load and accept so a redirect never lets a stale word through.
module ins_fetch_ir #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned INS_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic              ir_ready,
  input  logic [INS_W-1:0]  rom_ins,
  input  logic [ADDR_W-1:0] pc,
  output logic [INS_W-1:0]  ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid
);

  logic [INS_W-1:0]  ir_q;
  logic [ADDR_W-1:0] ir_pc_q;
  logic              ir_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else if (flush) begin
      ir_valid_q <= 1'b0;
    end else if (load) begin
      ir_q       <= rom_ins;
      ir_pc_q    <= pc;
      ir_valid_q <= 1'b1;
    end else if (ir_valid_q && ir_ready) begin
      ir_valid_q <= 1'b0;
    end
  end

  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;

endmodule

// File: rtl/ins_fetch_ctrl.sv
// Fetch controller: owns the PC and fetch FSM, addresses the async ROM and feeds the IR.
// The ROM is read combinationally at pc, so a load captures the word in the same cycle.
module ins_fetch_ctrl
  import ins_fetch_ctrl_pkg::*;
#(
  parameter int unsigned     ADDR_W   = 8,
  parameter int unsigned     INS_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [6:0]      HALT_OPC = HaltOpc
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INS_W-1:0]  rom_ins,
  output logic [INS_W-1:0]  ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       fetch_cnt
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       cnt_q;
  logic              busy_q;
  logic              halted_q;
  logic              load;
  logic              flush;

  assign load  = (state_q == StFetch) && !redirect && (!ir_valid || ir_ready);
  assign flush = redirect && (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StFetch;
            busy_q  <= 1'b1;
          end
        end
        StFetch: begin
          if (redirect) begin
            pc_q <= redirect_addr;
          end else if (load) begin
            pc_q  <= pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            cnt_q <= cnt_q + 16'd1;
            // The halt word itself is still delivered to decode.
            if (ins_opcode(rom_ins) == HALT_OPC) begin
              state_q  <= StHalt;
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
            end
          end
        end
        StHalt: begin
          if (redirect) begin
            pc_q     <= redirect_addr;
            state_q  <= StFetch;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= StIdle;
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  ins_fetch_ir #(
    .ADDR_W(ADDR_W),
    .INS_W (INS_W)
  ) u_ir (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .flush   (flush),
    .ir_ready(ir_ready),
    .rom_ins (rom_ins),
    .pc      (pc_q),
    .ir      (ir),
    .ir_pc   (ir_pc),
    .ir_valid(ir_valid)
  );

  assign rom_addr  = pc_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// Bench for ins_fetch_ctrl: directed vector table, corner-case sequences, then random
// stimulus against a rule-level reference model with a modelled async ROM.
module tb_ins_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_ins;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect;
  logic [7:0]  redirect_addr;
  logic        busy;
  logic        halted;
  logic [15:0] fetch_cnt;

  logic [15:0] rom [256];
  assign rom_ins = rom[rom_addr];

  int checks;
  int errors;

  ins_fetch_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .rom_addr     (rom_addr),
    .rom_ins      (rom_ins),
    .ir           (ir),
    .ir_pc        (ir_pc),
    .ir_valid     (ir_valid),
    .ir_ready     (ir_ready),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .busy         (busy),
    .halted       (halted),
    .fetch_cnt    (fetch_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        start;
    logic        ready;
    logic        redir;
    logic [7:0]  raddr;
    logic        valid;
    logic [15:0] ir;
    logic [7:0]  irpc;
    logic [15:0] cnt;
    logic        busy;
    logic        halted;
    logic [7:0]  pc;
  } vec_t;

  vec_t tbl [12];

  // Reference model state, derived from the handshake/redirect/halt rules.
  bit          m_started;
  bit          m_halted;
  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  logic [7:0]  m_irpc;
  bit          m_valid;
  logic [15:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic v, input logic [15:0] i,
                            input logic [7:0] ip, input logic [15:0] c, input logic b,
                            input logic h, input logic [7:0] p);
    chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(v));
    chk({tag, ".ir"}, 32'(ir), 32'(i));
    chk({tag, ".ir_pc"}, 32'(ir_pc), 32'(ip));
    chk({tag, ".fetch_cnt"}, 32'(fetch_cnt), 32'(c));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".halted"}, 32'(halted), 32'(h));
    chk({tag, ".rom_addr"}, 32'(rom_addr), 32'(p));
  endtask

  task automatic drive(input logic s, input logic r, input logic d, input logic [7:0] a);
    start         = s;
    ir_ready      = r;
    redirect      = d;
    redirect_addr = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_edge();
    logic [15:0] w;
    if (!m_started) begin
      if (start) m_started = 1'b1;
    end else if (redirect) begin
      m_pc    = redirect_addr;
      m_valid = 1'b0;
      m_halted = 1'b0;
    end else if (!m_halted && (!m_valid || ir_ready)) begin
      w       = rom[m_pc];
      m_ir    = w;
      m_irpc  = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 8'd1;
      m_cnt   = m_cnt + 16'd1;
      if (w[15:9] == 7'h7F) m_halted = 1'b1;
    end else if (m_valid && ir_ready) begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] w;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) begin
      w = '0;
      w[8:6] = 3'(i % 8);
      w[5:3] = 3'((i + 1) % 8);
      w[2:0] = 3'((i + 2) % 8);
      rom[i] = w;
    end
    rom[8'h7F] = 16'hFE00;

    // start, ready, redirect, raddr | valid, ir, ir_pc, cnt, busy, halted, pc
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 16'h0000, 8'h00, 16'd0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 16'h0000, 8'h00, 16'd0, 1'b1, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'h000A, 8'h00, 16'd1, 1'b1, 1'b0, 8'h01};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'h0053, 8'h01, 16'd2, 1'b1, 1'b0, 8'h02};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h0053, 8'h01, 16'd2, 1'b1, 1'b0, 8'h02};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h0053, 8'h01, 16'd2, 1'b1, 1'b0, 8'h02};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h0053, 8'h01, 16'd2, 1'b1, 1'b0, 8'h02};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'h009C, 8'h02, 16'd3, 1'b1, 1'b0, 8'h03};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'h00E5, 8'h03, 16'd4, 1'b1, 1'b0, 8'h04};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 16'h00E5, 8'h03, 16'd4, 1'b1, 1'b0, 8'hFF};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'h01C1, 8'hFF, 16'd5, 1'b1, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'h000A, 8'h00, 16'd6, 1'b1, 1'b0, 8'h01};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    #2;
    expect_all("reset", 1'b0, 16'h0, 8'h0, 16'd0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].start, tbl[i].ready, tbl[i].redir, tbl[i].raddr);
      step();
      expect_all($sformatf("vec%0d", i), tbl[i].valid, tbl[i].ir, tbl[i].irpc, tbl[i].cnt,
                 tbl[i].busy, tbl[i].halted, tbl[i].pc);
    end

    // Halt: 7E then the halt word from 7F, then drain and stay put.
    drive(1'b0, 1'b1, 1'b1, 8'h7E); step();
    expect_all("h_redir", 1'b0, 16'h000A, 8'h00, 16'd6, 1'b1, 1'b0, 8'h7E);
    drive(1'b0, 1'b1, 1'b0, 8'h00); step();
    expect_all("h_7e", 1'b1, 16'h01B8, 8'h7E, 16'd7, 1'b1, 1'b0, 8'h7F);
    step();
    expect_all("h_7f", 1'b1, 16'hFE00, 8'h7F, 16'd8, 1'b0, 1'b1, 8'h80);
    drive(1'b1, 1'b0, 1'b0, 8'h00); step();
    expect_all("h_hold", 1'b1, 16'hFE00, 8'h7F, 16'd8, 1'b0, 1'b1, 8'h80);
    drive(1'b0, 1'b1, 1'b0, 8'h00); step();
    expect_all("h_drain", 1'b0, 16'hFE00, 8'h7F, 16'd8, 1'b0, 1'b1, 8'h80);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_all($sformatf("h_idle%0d", i), 1'b0, 16'hFE00, 8'h7F, 16'd8, 1'b0, 1'b1, 8'h80);
    end
    drive(1'b0, 1'b1, 1'b1, 8'h00); step();
    expect_all("h_resume", 1'b0, 16'hFE00, 8'h7F, 16'd8, 1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h00); step();
    expect_all("h_first", 1'b1, 16'h000A, 8'h00, 16'd9, 1'b1, 1'b0, 8'h01);

    // Redirect while the halt word is on rom_ins with ready high: no load, no halt.
    drive(1'b0, 1'b1, 1'b1, 8'h7E); step();
    expect_all("s_redir", 1'b0, 16'h000A, 8'h00, 16'd9, 1'b1, 1'b0, 8'h7E);
    drive(1'b0, 1'b1, 1'b0, 8'h00); step();
    expect_all("s_7e", 1'b1, 16'h01B8, 8'h7E, 16'd10, 1'b1, 1'b0, 8'h7F);
    drive(1'b0, 1'b1, 1'b1, 8'h10); step();
    expect_all("s_win", 1'b0, 16'h01B8, 8'h7E, 16'd10, 1'b1, 1'b0, 8'h10);
    drive(1'b0, 1'b1, 1'b0, 8'h00); step();
    expect_all("s_10", 1'b1, 16'h000A, 8'h10, 16'd11, 1'b1, 1'b0, 8'h11);

    // Async reset between edges during a stall.
    drive(1'b0, 1'b0, 1'b0, 8'h00); step();
    expect_all("r_stall", 1'b1, 16'h000A, 8'h10, 16'd11, 1'b1, 1'b0, 8'h11);
    #2;
    rst_n = 1'b0;
    #1;
    expect_all("r_async", 1'b0, 16'h0, 8'h0, 16'd0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    step(); step();
    expect_all("r_idle", 1'b0, 16'h0, 8'h0, 16'd0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h00); step();
    drive(1'b0, 1'b1, 1'b0, 8'h00); step();
    expect_all("r_resume", 1'b1, 16'h000A, 8'h00, 16'd1, 1'b1, 1'b0, 8'h01);

    // Random phase: random ROM with occasional halt words.
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if ($urandom_range(15) == 0) w[15:9] = 7'h7F;
      else w[15:9] = 7'($urandom_range(126));
      rom[i] = w;
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    m_started = 1'b0; m_halted = 1'b0; m_pc = 8'h00; m_ir = '0; m_irpc = '0;
    m_valid = 1'b0; m_cnt = '0;
    for (int n = 0; n < 1500; n++) begin
      drive(($urandom_range(7) == 0), ($urandom_range(3) != 0), ($urandom_range(9) == 0),
            8'($urandom));
      model_edge();
      step();
      expect_all($sformatf("rnd%0d", n), m_valid, m_ir, m_irpc, m_cnt,
                 m_started && !m_halted, m_halted, m_pc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
